// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline constants (hazard FSM states, r0, branch/jump opcodes)
package mips_pipe_pkg;
   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_STALL = 1'b1;
   localparam int   REG_ZERO = 0;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
endpackage

// File: rtl/haz_reg_match.sv
// haz_reg_match: compares the rs/rt sources against one destination register, r0 never matches
module haz_reg_match
   import mips_pipe_pkg::*;
#(
   parameter int NB_ADDR = 5
) (
   input  logic [NB_ADDR-1:0] rs,
   input  logic [NB_ADDR-1:0] rt,
   input  logic               uses_rs,
   input  logic               uses_rt,
   input  logic [NB_ADDR-1:0] rd,
   output logic               hit
);
   // a hit needs a real destination and a source that is actually read
   always_comb hit = (rd != NB_ADDR'(REG_ZERO)) && ((uses_rs && rs == rd) || (uses_rt && rt == rd));
endmodule

// File: rtl/seg_hazard_stall_ctrl.sv
// seg_hazard_stall_ctrl: ID-stage hazard detection, multi-cycle stall sequencing and IF flush; optional HAZ_STATS_EN adds stall/flush counters
module seg_hazard_stall_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int NB_ADDR      = 5,
   parameter int LOAD_LAT     = 1,
   parameter int BRANCH_IN_ID = 1,
   parameter int NB_CNT       = 3
`ifdef HAZ_STATS_EN
   , parameter int NB_STAT    = 16
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid_id,
   input  logic [NB_ADDR-1:0] i_rs_id,
   input  logic [NB_ADDR-1:0] i_rt_id,
   input  logic               i_uses_rs,
   input  logic               i_uses_rt,
   input  logic               i_is_branch,
   input  logic               i_is_jump,
   input  logic               i_branch_taken,
   input  logic               i_MemRead_ex,
   input  logic               i_RegWrite_ex,
   input  logic [NB_ADDR-1:0] i_rd_ex,
   input  logic               i_MemRead_mem,
   input  logic [NB_ADDR-1:0] i_rd_mem,
`ifdef HAZ_STATS_EN
   output logic [NB_STAT-1:0] o_stall_cycles,
   output logic [NB_STAT-1:0] o_flush_count,
`endif
   output logic               o_stall_flag,
   output logic               o_bubble,
   output logic               o_flush_if
);
   localparam logic [NB_CNT:0] N_ONE  = (NB_CNT+1)'(1);
   localparam logic [NB_CNT:0] N_TWO  = (NB_CNT+1)'(2);
   localparam logic [NB_CNT:0] LAT_LU = (NB_CNT+1)'(LOAD_LAT);
   localparam logic [NB_CNT:0] LAT_BR = (NB_CNT+1)'(LOAD_LAT + 1);

   logic              hit_ex, hit_mem;
   logic              br_chk, haz_lu, haz_br_alu, haz_br_ld, haz_br_mem, haz, long_haz;
   logic [NB_CNT:0]   need;
   logic              state, state_nxt;
   logic [NB_CNT-1:0] cnt, cnt_nxt;

   haz_reg_match #(.NB_ADDR(NB_ADDR)) u_match_ex (
      .rs(i_rs_id), .rt(i_rt_id), .uses_rs(i_uses_rs), .uses_rt(i_uses_rt), .rd(i_rd_ex), .hit(hit_ex)
   );

   haz_reg_match #(.NB_ADDR(NB_ADDR)) u_match_mem (
      .rs(i_rs_id), .rt(i_rt_id), .uses_rs(i_uses_rs), .uses_rt(i_uses_rt), .rd(i_rd_mem), .hit(hit_mem)
   );

   // classify the hazards of the ID instruction and pick the longest stall that applies
   always_comb begin
      br_chk     = (BRANCH_IN_ID != 0) && i_valid_id && i_is_branch;
      haz_lu     = i_valid_id && i_MemRead_ex && hit_ex;
      haz_br_alu = br_chk && i_RegWrite_ex && !i_MemRead_ex && hit_ex;
      haz_br_ld  = br_chk && i_MemRead_ex && hit_ex;
      haz_br_mem = br_chk && i_MemRead_mem && hit_mem;
      haz        = haz_lu || haz_br_alu || haz_br_ld || haz_br_mem;
      need       = haz_br_ld ? LAT_BR : haz_lu ? LAT_LU : N_ONE;
      long_haz   = haz && (need != N_ONE);
   end

   // state and remaining-stall counter; reset aborts any stall in progress
   always_ff @(posedge i_clk)
      if (!i_rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end

   // detection cycle is the first stall cycle, so STALL covers the remaining need-1 cycles
   always_comb begin
      if (state == ST_STALL) begin
         state_nxt = (cnt == '0) ? ST_RUN : ST_STALL;
         cnt_nxt   = (cnt == '0) ? cnt : cnt - NB_CNT'(1);
      end else begin
         state_nxt = long_haz ? ST_STALL : ST_RUN;
         cnt_nxt   = long_haz ? NB_CNT'(need - N_TWO) : cnt;
      end
   end

   // stall wins over flush; a held jump/branch flushes on the first free cycle
   always_comb begin
      o_stall_flag = i_rst && (state == ST_STALL || haz);
      o_bubble     = o_stall_flag;
      o_flush_if   = i_rst && (i_is_jump || i_branch_taken) && !o_stall_flag;
   end

`ifdef HAZ_STATS_EN
   // saturating counts of stall and flush cycles
   always_ff @(posedge i_clk)
      if (!i_rst) begin
         o_stall_cycles <= '0;
         o_flush_count  <= '0;
      end else begin
         if (o_stall_flag && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + NB_STAT'(1);
         if (o_flush_if && !(&o_flush_count)) o_flush_count <= o_flush_count + NB_STAT'(1);
      end
`endif
endmodule

// File: tb/tb_seg_hazard_stall_ctrl.sv
// tb_seg_hazard_stall_ctrl: directed and random checks of two hazard controllers (LOAD_LAT 1 and 3) against a remaining-cycles model
module tb_seg_hazard_stall_ctrl;
   logic       clk = 1'b0;
   logic       rst, valid_id, uses_rs, uses_rt, is_branch, is_jump, branch_taken;
   logic       mem_read_ex, reg_write_ex, mem_read_mem;
   logic [4:0] rs_id, rt_id, rd_ex, rd_mem;
   logic       stall1, bubble1, flush1, stall3, bubble3, flush3;
   int         checks = 0, errors = 0;
   int         rem1 = 0, rem3 = 0, idx = 0;
   logic       hs1[16], hs3[16], hf1[16], hf3[16];
`ifdef HAZ_STATS_EN
   logic [15:0] sc1, fc1, sc3, fc3;
   int          esc1 = 0, efc1 = 0, esc3 = 0, efc3 = 0;
`endif

   always #5 clk = ~clk;

   seg_hazard_stall_ctrl #(.LOAD_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_valid_id(valid_id), .i_rs_id(rs_id), .i_rt_id(rt_id),
      .i_uses_rs(uses_rs), .i_uses_rt(uses_rt), .i_is_branch(is_branch), .i_is_jump(is_jump),
      .i_branch_taken(branch_taken), .i_MemRead_ex(mem_read_ex), .i_RegWrite_ex(reg_write_ex),
      .i_rd_ex(rd_ex), .i_MemRead_mem(mem_read_mem), .i_rd_mem(rd_mem),
`ifdef HAZ_STATS_EN
      .o_stall_cycles(sc1), .o_flush_count(fc1),
`endif
      .o_stall_flag(stall1), .o_bubble(bubble1), .o_flush_if(flush1)
   );

   seg_hazard_stall_ctrl #(.LOAD_LAT(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_valid_id(valid_id), .i_rs_id(rs_id), .i_rt_id(rt_id),
      .i_uses_rs(uses_rs), .i_uses_rt(uses_rt), .i_is_branch(is_branch), .i_is_jump(is_jump),
      .i_branch_taken(branch_taken), .i_MemRead_ex(mem_read_ex), .i_RegWrite_ex(reg_write_ex),
      .i_rd_ex(rd_ex), .i_MemRead_mem(mem_read_mem), .i_rd_mem(rd_mem),
`ifdef HAZ_STATS_EN
      .o_stall_cycles(sc3), .o_flush_count(fc3),
`endif
      .o_stall_flag(stall3), .o_bubble(bubble3), .o_flush_if(flush3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // total stall cycles the ID instruction needs right now, from the hazard rules
   function automatic int need(int ll);
      bit m_ex, m_mem;
      int n = 0;
      m_ex  = rd_ex != 0 && ((uses_rs && rs_id == rd_ex) || (uses_rt && rt_id == rd_ex));
      m_mem = rd_mem != 0 && ((uses_rs && rs_id == rd_mem) || (uses_rt && rt_id == rd_mem));
      if (!valid_id) return 0;
      if (mem_read_ex && m_ex) n = ll;
      if (is_branch) begin
         if (reg_write_ex && !mem_read_ex && m_ex && n < 1) n = 1;
         if (mem_read_ex && m_ex) n = ll + 1;
         if (mem_read_mem && m_mem && n < 1) n = 1;
      end
      return n;
   endfunction

   task automatic step();
      int  n1, n3;
      logic es1, es3, ef1, ef3;
      n1  = need(1);
      n3  = need(3);
      es1 = rst && (rem1 > 0 || n1 > 0);
      es3 = rst && (rem3 > 0 || n3 > 0);
      ef1 = rst && (is_jump || branch_taken) && !es1;
      ef3 = rst && (is_jump || branch_taken) && !es3;
      @(negedge clk);
      check("stall1", stall1, es1);
      check("bubble1", bubble1, es1);
      check("flush1", flush1, ef1);
      check("stall3", stall3, es3);
      check("bubble3", bubble3, es3);
      check("flush3", flush3, ef3);
`ifdef HAZ_STATS_EN
      check("stall_cnt1", sc1, esc1);
      check("flush_cnt1", fc1, efc1);
      check("stall_cnt3", sc3, esc3);
      check("flush_cnt3", fc3, efc3);
`endif
      if (idx < 16) begin
         hs1[idx] = stall1;
         hs3[idx] = stall3;
         hf1[idx] = flush1;
         hf3[idx] = flush3;
      end
      idx++;
      @(posedge clk);
      rem1 = !rst ? 0 : rem1 > 0 ? rem1 - 1 : n1 > 0 ? n1 - 1 : 0;
      rem3 = !rst ? 0 : rem3 > 0 ? rem3 - 1 : n3 > 0 ? n3 - 1 : 0;
`ifdef HAZ_STATS_EN
      esc1 = !rst ? 0 : esc1 + int'(es1);
      efc1 = !rst ? 0 : efc1 + int'(ef1);
      esc3 = !rst ? 0 : esc3 + int'(es3);
      efc3 = !rst ? 0 : efc3 + int'(ef3);
`endif
      #1;
   endtask

   task automatic idle();
      rst = 1'b1; valid_id = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; is_branch = 1'b0;
      is_jump = 1'b0; branch_taken = 1'b0; mem_read_ex = 1'b0; reg_write_ex = 1'b0;
      mem_read_mem = 1'b0; rs_id = '0; rt_id = '0; rd_ex = '0; rd_mem = '0;
      repeat (4) step();
      idx = 0;
   endtask

   task automatic clear_ex();
      mem_read_ex = 1'b0; reg_write_ex = 1'b0; rd_ex = '0;
   endtask

   // LW $1 in EX, ADDU reading rs = 1 in ID
   task automatic load_use();
      valid_id = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; rs_id = 5'd1; rt_id = 5'd3;
      mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd1;
   endtask

   function automatic int sum(bit which3, int len);
      int s = 0;
      for (int i = 0; i < len; i++) s += which3 ? int'(hs3[i]) : int'(hs1[i]);
      return s;
   endfunction

   initial begin
      idle();
      rst = 1'b0;
      load_use();
      is_jump = 1'b1;
      step();
      check("rst_stall1", hs1[0], 0);
      check("rst_stall3", hs3[0], 0);
      check("rst_flush1", hf1[0], 0);

      idle();
      load_use();
      step();
      clear_ex();
      repeat (5) step();
      check("lu_total1", sum(0, 6), 1);
      check("lu_total3", sum(1, 6), 3);
      check("lu3_cyc2", hs3[2], 1);
      check("lu3_cyc3", hs3[3], 0);

      idle();
      valid_id = 1'b1; is_branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; rs_id = 5'd5; rt_id = 5'd2;
      mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd2;
      step();
      clear_ex();
      repeat (6) step();
      check("br_ld_total1", sum(0, 7), 2);
      check("br_ld_total3", sum(1, 7), 4);

      idle();
      valid_id = 1'b1; is_branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; rs_id = 5'd5; rt_id = 5'd2;
      reg_write_ex = 1'b1; rd_ex = 5'd2;
      step();
      clear_ex();
      repeat (3) step();
      check("br_alu_total1", sum(0, 4), 1);
      check("br_alu_total3", sum(1, 4), 1);

      idle();
      valid_id = 1'b1; uses_rs = 1'b1; rs_id = 5'd0; mem_read_ex = 1'b1; rd_ex = 5'd0;
      step();
      check("r0_stall1", hs1[0], 0);
      check("r0_stall3", hs3[0], 0);

      idle();
      valid_id = 1'b1; is_jump = 1'b1;
      step();
      is_jump = 1'b0;
      step();
      check("jump_flush", hf1[0], 1);
      check("jump_flush_end", hf1[1], 0);

      idle();
      load_use();
      is_jump = 1'b1;
      step();
      clear_ex();
      repeat (4) step();
      check("jlu_flush1_c0", hf1[0], 0);
      check("jlu_flush1_c1", hf1[1], 1);
      check("jlu_flush3_c2", hf3[2], 0);
      check("jlu_flush3_c3", hf3[3], 1);

      idle();
      load_use();
      step();
      clear_ex();
      step();
      rst = 1'b0;
      step();
`ifdef HAZ_STATS_EN
      check("rst_stat_stall", sc3, 0);
      check("rst_stat_flush", fc3, 0);
`endif
      rst = 1'b1;
      step();
      check("rst_mid_c1", hs3[1], 1);
      check("rst_mid_c2", hs3[2], 0);
      check("rst_mid_c3", hs3[3], 0);

      idle();
      for (int i = 0; i < 800; i++) begin
         rst          = $urandom_range(0, 39) != 0;
         valid_id     = $urandom_range(0, 7) != 0;
         uses_rs      = $urandom_range(0, 1) != 0;
         uses_rt      = $urandom_range(0, 1) != 0;
         is_branch    = $urandom_range(0, 2) == 0;
         is_jump      = $urandom_range(0, 5) == 0;
         branch_taken = $urandom_range(0, 3) == 0;
         mem_read_ex  = $urandom_range(0, 2) == 0;
         reg_write_ex = $urandom_range(0, 1) != 0;
         mem_read_mem = $urandom_range(0, 2) == 0;
         rs_id        = 5'($urandom_range(0, 3));
         rt_id        = 5'($urandom_range(0, 3));
         rd_ex        = 5'($urandom_range(0, 3));
         rd_mem       = 5'($urandom_range(0, 3));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
